// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Fetch FSM encodings, data width and PC helpers live here.
package fetch_unit_pkg;

  localparam int unsigned DATA_SIZE = 32;
  localparam logic [DATA_SIZE-1:0] PC_INC = 32'd4;
  localparam logic [DATA_SIZE-1:0] DEF_NOP_INST = 32'h0000_0013;
  localparam logic [DATA_SIZE-1:0] PC_ALIGN_MASK = 32'h0000_0003;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_WAIT  = 2'd2,
    FS_HOLD  = 2'd3
  } fetch_state_e;

  // Branch targets are word-aligned by silently clearing the low two bits.
  function automatic logic [DATA_SIZE-1:0] align_pc(input logic [DATA_SIZE-1:0] addr);
    return addr & ~PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold, otherwise the
// valid bit drops while pc/inst keep their last values.
module ifid_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [DATA_SIZE-1:0] NOP_INST = DEF_NOP_INST
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 load,
  input  logic                 stall,
  input  logic [DATA_SIZE-1:0] load_pc,
  input  logic [DATA_SIZE-1:0] load_inst,
  output logic                 id_valid,
  output logic [DATA_SIZE-1:0] id_pc,
  output logic [DATA_SIZE-1:0] id_inst
);

  logic                 valid_q, valid_d;
  logic [DATA_SIZE-1:0] pc_q, pc_d;
  logic [DATA_SIZE-1:0] inst_q, inst_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (flush) begin
      // id_pc is deliberately left alone so the branch unit sees a stable pc.
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = load_pc;
      inst_d  = load_inst;
    end else if (!stall) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= NOP_INST;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign id_valid = valid_q;
  assign id_pc    = pc_q;
  assign id_inst  = inst_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem requests, stall hold
// buffer and branch redirect with stale-response dropping.
//
// imem handshake: a request transfers on a cycle where imem_req && imem_ready;
// imem_req/imem_addr stay stable until then. The single response is the one
// cycle imem_valid pulse observed in FS_WAIT; imem_valid anywhere else is ignored.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [DATA_SIZE-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [DATA_SIZE-1:0] NOP_INST = DEF_NOP_INST
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 branchFlag,
  input  logic [DATA_SIZE-1:0] branchAddr,
  output logic                 imem_req,
  output logic [DATA_SIZE-1:0] imem_addr,
  input  logic                 imem_ready,
  input  logic                 imem_valid,
  input  logic [DATA_SIZE-1:0] imem_rdata,
  output logic                 id_valid,
  output logic [DATA_SIZE-1:0] id_pc,
  output logic [DATA_SIZE-1:0] id_inst,
  output fetch_state_e         dbg_state
);

  fetch_state_e         state_q, state_d;
  logic [DATA_SIZE-1:0] pc_q, pc_d;
  logic [DATA_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic                 drop_q, drop_d;
  logic                 hold_valid_q, hold_valid_d;
  logic [DATA_SIZE-1:0] hold_pc_q, hold_pc_d;
  logic [DATA_SIZE-1:0] hold_inst_q, hold_inst_d;

  logic                 ifid_load;
  logic [DATA_SIZE-1:0] ifid_pc;
  logic [DATA_SIZE-1:0] ifid_inst;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
    drop_d       = drop_q;
    hold_valid_d = hold_valid_q;
    hold_pc_d    = hold_pc_q;
    hold_inst_d  = hold_inst_q;
    ifid_load    = 1'b0;
    ifid_pc      = fetch_pc_q;
    ifid_inst    = imem_rdata;

    unique case (state_q)
      FS_IDLE: state_d = FS_FETCH;
      FS_FETCH: begin
        if (imem_ready) begin
          fetch_pc_d = pc_q;
          pc_d       = pc_q + PC_INC;
          state_d    = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (imem_valid) begin
          state_d = FS_FETCH;
          if (drop_q) begin
            drop_d = 1'b0;
          end else if (!stall) begin
            ifid_load = 1'b1;
          end else begin
            hold_valid_d = 1'b1;
            hold_pc_d    = fetch_pc_q;
            hold_inst_d  = imem_rdata;
            state_d      = FS_HOLD;
          end
        end
      end
      FS_HOLD: begin
        if (!stall && hold_valid_q) begin
          ifid_load    = 1'b1;
          ifid_pc      = hold_pc_q;
          ifid_inst    = hold_inst_q;
          hold_valid_d = 1'b0;
          state_d      = FS_FETCH;
        end
      end
      default: state_d = FS_IDLE;
    endcase

    // A taken branch overrides everything above, including stall.
    if (branchFlag) begin
      pc_d         = align_pc(branchAddr);
      hold_valid_d = 1'b0;
      unique case (state_q)
        FS_FETCH: begin
          if (imem_ready) begin
            state_d = FS_WAIT;
            drop_d  = 1'b1;
          end else begin
            state_d = FS_FETCH;
          end
        end
        FS_WAIT: begin
          if (imem_valid) begin
            state_d = FS_FETCH;
            drop_d  = 1'b0;
          end else begin
            state_d = FS_WAIT;
            drop_d  = 1'b1;
          end
        end
        default: state_d = FS_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FS_IDLE;
      pc_q         <= RESET_PC;
      fetch_pc_q   <= '0;
      drop_q       <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_pc_q    <= '0;
      hold_inst_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_pc_q   <= fetch_pc_d;
      drop_q       <= drop_d;
      hold_valid_q <= hold_valid_d;
      hold_pc_q    <= hold_pc_d;
      hold_inst_q  <= hold_inst_d;
    end
  end

  assign imem_req  = (state_q == FS_FETCH);
  assign imem_addr = pc_q;
  assign dbg_state = state_q;

  ifid_reg #(
    .NOP_INST(NOP_INST)
  ) u_ifid_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (branchFlag),
    .load     (ifid_load),
    .stall    (stall),
    .load_pc  (ifid_pc),
    .load_inst(ifid_inst),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_inst  (id_inst)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an in-bench 1-cycle memory answers with
// rdata = addr + 0x100 unless overridden; each task checks its own scenario.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clk;
  logic         rst_n;
  logic         stall;
  logic         branchFlag;
  logic [31:0]  branchAddr;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ready;
  logic         imem_valid;
  logic [31:0]  imem_rdata;
  logic         id_valid;
  logic [31:0]  id_pc;
  logic [31:0]  id_inst;
  fetch_state_e dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // memory model controls
  logic        ready_en     = 1'b1;
  logic        hold_resp    = 1'b0;
  logic        stray        = 1'b0;
  logic        override_en  = 1'b0;
  logic [31:0] override_val = '0;
  logic        pending      = 1'b0;
  logic [31:0] pend_addr    = '0;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(NOP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .branchFlag(branchFlag),
    .branchAddr(branchAddr),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ready(imem_ready),
    .imem_valid(imem_valid),
    .imem_rdata(imem_rdata),
    .id_valid  (id_valid),
    .id_pc     (id_pc),
    .id_inst   (id_inst),
    .dbg_state (dbg_state)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive memory inputs for one cycle, advance one edge, sample at edge+1.
  task automatic cycle();
    logic        acc;
    logic [31:0] acc_addr;
    imem_ready = ready_en;
    imem_valid = (pending && !hold_resp) || stray;
    imem_rdata = override_en ? override_val : pend_addr + 32'h100;
    acc      = imem_req && imem_ready;
    acc_addr = imem_addr;
    @(posedge clk);
    #1;
    if (acc) begin
      pending   = 1'b1;
      pend_addr = acc_addr;
    end else if (!hold_resp) begin
      pending = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; stall = 1'b0; branchFlag = 1'b0; branchAddr = '0;
    imem_ready = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if ({imem_req, id_valid, id_pc, id_inst} !== {1'b0, 1'b0, 32'h0, NOP} || dbg_state !== FS_IDLE)
      $display("FAIL reset_values: req=%b v=%b pc=%h inst=%h st=%0d exp 0 0 0 %h IDLE",
               imem_req, id_valid, id_pc, id_inst, dbg_state, NOP);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL idle_no_req: req=%b exp 0", imem_req);
    else n_pass++;
    cycle();
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0} || dbg_state !== FS_FETCH)
      $display("FAIL first_req: req=%b addr=%h st=%0d exp 1 00000000 FETCH", imem_req, imem_addr, dbg_state);
    else n_pass++;
  endtask

  task automatic test_sequence();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'(4 * k)})
        $display("FAIL seq_req%0d: req=%b addr=%h exp 1 %h", k, imem_req, imem_addr, 32'(4 * k));
      else n_pass++;
      cycle();
      n_checks++;
      if (id_valid !== 1'b0 || dbg_state !== FS_WAIT)
        $display("FAIL seq_gap%0d: v=%b st=%0d exp 0 WAIT", k, id_valid, dbg_state);
      else n_pass++;
      cycle();
      n_checks++;
      if ({id_valid, id_pc, id_inst} !== {1'b1, 32'(4 * k), 32'(32'h100 + 4 * k)})
        $display("FAIL seq_out%0d: v=%b pc=%h inst=%h exp 1 %h %h", k, id_valid, id_pc, id_inst,
                 32'(4 * k), 32'(32'h100 + 4 * k));
      else n_pass++;
    end
  endtask

  task automatic test_ready_low();
    ready_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0000_000C} || dbg_state !== FS_FETCH)
        $display("FAIL ready_low%0d: req=%b addr=%h st=%0d exp 1 0000000c FETCH", k, imem_req, imem_addr, dbg_state);
      else n_pass++;
    end
    ready_en = 1'b1;
    cycle();
    cycle();
    n_checks++;
    if ({id_valid, id_pc, id_inst} !== {1'b1, 32'h0000_000C, 32'h0000_010C})
      $display("FAIL ready_resume: v=%b pc=%h inst=%h exp 1 0000000c 0000010c", id_valid, id_pc, id_inst);
    else n_pass++;
  endtask

  task automatic test_stall_hold();
    cycle();                       // accept pc 0x10
    stall = 1'b1; override_en = 1'b1; override_val = 32'hDEAD_0033;
    for (int k = 0; k < 4; k++) begin
      cycle();
      n_checks++;
      if (dbg_state !== FS_HOLD || {id_valid, id_pc, id_inst} !== {1'b0, 32'h0000_000C, 32'h0000_010C})
        $display("FAIL stall_hold%0d: st=%0d v=%b pc=%h inst=%h exp HOLD 0 0000000c 0000010c",
                 k, dbg_state, id_valid, id_pc, id_inst);
      else n_pass++;
    end
    stall = 1'b0;
    cycle();
    override_en = 1'b0;
    n_checks++;
    if ({id_valid, id_pc, id_inst} !== {1'b1, 32'h0000_0010, 32'hDEAD_0033} || dbg_state !== FS_FETCH)
      $display("FAIL stall_release: v=%b pc=%h inst=%h st=%0d exp 1 00000010 dead0033 FETCH",
               id_valid, id_pc, id_inst, dbg_state);
    else n_pass++;
  endtask

  task automatic test_branch_wait();
    cycle();                       // accept pc 0x14, enter WAIT
    hold_resp = 1'b1;
    branchFlag = 1'b1; branchAddr = 32'h0000_0500;
    cycle();
    branchAddr = 32'h0000_0203;    // back-to-back: last one wins
    cycle();
    branchFlag = 1'b0;
    n_checks++;
    if ({id_valid, id_pc, id_inst} !== {1'b0, 32'h0000_0010, NOP} || dbg_state !== FS_WAIT)
      $display("FAIL branch_flush: v=%b pc=%h inst=%h st=%0d exp 0 00000010 %h WAIT",
               id_valid, id_pc, id_inst, dbg_state, NOP);
    else n_pass++;
    hold_resp = 1'b0;
    cycle();                       // stale response for 0x14 arrives
    n_checks++;
    if ({id_valid, id_inst} !== {1'b0, NOP} || {imem_req, imem_addr} !== {1'b1, 32'h0000_0200})
      $display("FAIL branch_drop: v=%b inst=%h req=%b addr=%h exp 0 %h 1 00000200",
               id_valid, id_inst, imem_req, imem_addr, NOP);
    else n_pass++;
    cycle();
    cycle();
    n_checks++;
    if ({id_valid, id_pc, id_inst} !== {1'b1, 32'h0000_0200, 32'h0000_0300})
      $display("FAIL branch_target: v=%b pc=%h inst=%h exp 1 00000200 00000300", id_valid, id_pc, id_inst);
    else n_pass++;
  endtask

  task automatic test_branch_ready();
    ready_en = 1'b0;
    branchFlag = 1'b1; branchAddr = 32'h0000_0040;
    cycle();
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0040} || {id_valid, id_inst} !== {1'b0, NOP})
      $display("FAIL branch_fetch: req=%b addr=%h v=%b inst=%h exp 1 00000040 0 %h",
               imem_req, imem_addr, id_valid, id_inst, NOP);
    else n_pass++;
    ready_en = 1'b1; branchAddr = 32'h0000_0080;
    cycle();                       // request for 0x40 accepted alongside branch
    branchFlag = 1'b0;
    cycle();                       // its response must be dropped
    n_checks++;
    if ({id_valid, id_inst} !== {1'b0, NOP} || {imem_req, imem_addr} !== {1'b1, 32'h0000_0080})
      $display("FAIL branch_ready_drop: v=%b inst=%h req=%b addr=%h exp 0 %h 1 00000080",
               id_valid, id_inst, imem_req, imem_addr, NOP);
    else n_pass++;
    cycle();
    cycle();
    n_checks++;
    if ({id_valid, id_pc, id_inst} !== {1'b1, 32'h0000_0080, 32'h0000_0180})
      $display("FAIL branch_ready_target: v=%b pc=%h inst=%h exp 1 00000080 00000180", id_valid, id_pc, id_inst);
    else n_pass++;
  endtask

  task automatic test_wrap_reset();
    ready_en = 1'b0;
    branchFlag = 1'b1; branchAddr = 32'hFFFF_FFFC;
    cycle();
    branchFlag = 1'b0; ready_en = 1'b1;
    cycle();
    cycle();
    n_checks++;
    if ({id_valid, id_pc, id_inst} !== {1'b1, 32'hFFFF_FFFC, 32'h0000_00FC} || imem_addr !== 32'h0)
      $display("FAIL wrap: v=%b pc=%h inst=%h addr=%h exp 1 fffffffc 000000fc 00000000",
               id_valid, id_pc, id_inst, imem_addr);
    else n_pass++;
    cycle();                       // accept pc 0, response pending
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, id_valid, id_pc, id_inst} !== {1'b0, 1'b0, 32'h0, NOP} || dbg_state !== FS_IDLE)
      $display("FAIL mid_reset: req=%b v=%b pc=%h inst=%h st=%0d exp 0 0 0 %h IDLE",
               imem_req, id_valid, id_pc, id_inst, dbg_state, NOP);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();                       // stray valid for pre-reset request, in IDLE
    n_checks++;
    if (id_valid !== 1'b0 || dbg_state !== FS_FETCH || imem_addr !== 32'h0)
      $display("FAIL stray_idle: v=%b st=%0d addr=%h exp 0 FETCH 00000000", id_valid, dbg_state, imem_addr);
    else n_pass++;
    ready_en = 1'b0; stray = 1'b1;
    cycle();                       // stray valid while in FETCH
    stray = 1'b0; ready_en = 1'b1;
    n_checks++;
    if (id_valid !== 1'b0 || dbg_state !== FS_FETCH)
      $display("FAIL stray_fetch: v=%b st=%0d exp 0 FETCH", id_valid, dbg_state);
    else n_pass++;
    cycle();
    cycle();
    n_checks++;
    if ({id_valid, id_pc, id_inst} !== {1'b1, 32'h0, 32'h0000_0100})
      $display("FAIL post_reset: v=%b pc=%h inst=%h exp 1 00000000 00000100", id_valid, id_pc, id_inst);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_ready_low();
    test_stall_hold();
    test_branch_wait();
    test_branch_ready();
    test_wrap_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
